// File: rtl/pb_input_port_if.sv
// Push-button port bundle between the raw button pins/core and pb_input_port.
// master = core/pin side, slave = conditioning block.
interface pb_input_port_if;
    localparam int unsigned NUM_PB = 4;

    logic [NUM_PB-1:0] pb_raw;
    logic              in_rd;
    logic [NUM_PB-1:0] pushbuttons;
    logic [NUM_PB-1:0] pb_level;
    logic [NUM_PB-1:0] pb_event;

    modport master (
        output pb_raw,
        output in_rd,
        input  pushbuttons,
        input  pb_level,
        input  pb_event
    );

    modport slave (
        input  pb_raw,
        input  in_rd,
        output pushbuttons,
        output pb_level,
        output pb_event
    );
endinterface

// File: rtl/pb_input_port.sv
// Push-button conditioning: 2-flop synchroniser, per-bit debounce FSM, optional sticky press latch.
// Define PB_STICKY_EN to present the press latch (cleared by in_rd) instead of the debounced level.
module pb_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    pb_input_port_if.slave   pb
);
    localparam int unsigned NUM_PB = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } pb_state_e;

    logic [NUM_PB-1:0] r_s1;
    logic [NUM_PB-1:0] r_s2;
    logic [NUM_PB-1:0] r_level;
    logic [NUM_PB-1:0] r_event;
    pb_state_e         r_state [NUM_PB];
    logic [CNT_W-1:0]  r_cnt   [NUM_PB];

    // Two-stage synchroniser for the asynchronous button pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= pb.pb_raw;
            r_s2 <= r_s1;
        end
    end

    // Independent debounce FSM per bit; a change is accepted after DEBOUNCE_CYCLES equal samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PB; i++) begin
                r_state[i] <= S_RELEASED;
                r_cnt[i]   <= '0;
            end
            r_level <= '0;
            r_event <= '0;
        end else begin
            r_event <= '0;
            for (int i = 0; i < NUM_PB; i++) begin
                case (r_state[i])
                    S_RELEASED: begin
                        if (r_s2[i]) begin
                            r_state[i] <= S_PRESS_WAIT;
                            r_cnt[i]   <= CNT_ONE;
                        end else begin
                            r_cnt[i]   <= '0;
                        end
                    end
                    S_PRESS_WAIT: begin
                        if (!r_s2[i]) begin
                            r_state[i] <= S_RELEASED;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_state[i] <= S_PRESSED;
                            r_cnt[i]   <= '0;
                            r_level[i] <= 1'b1;
                            r_event[i] <= 1'b1;
                        end else begin
                            r_cnt[i]   <= r_cnt[i] + CNT_ONE;
                        end
                    end
                    S_PRESSED: begin
                        if (!r_s2[i]) begin
                            r_state[i] <= S_RELEASE_WAIT;
                            r_cnt[i]   <= CNT_ONE;
                        end else begin
                            r_cnt[i]   <= '0;
                        end
                    end
                    S_RELEASE_WAIT: begin
                        if (r_s2[i]) begin
                            r_state[i] <= S_PRESSED;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_state[i] <= S_RELEASED;
                            r_cnt[i]   <= '0;
                            r_level[i] <= 1'b0;
                        end else begin
                            r_cnt[i]   <= r_cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state[i] <= S_RELEASED;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign pb.pb_level = r_level;
    assign pb.pb_event = r_event;

`ifdef PB_STICKY_EN
    logic [NUM_PB-1:0] r_latch;

    // Set beats clear so a press coinciding with the core's read is never lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_latch <= '0;
        end else begin
            r_latch <= (r_latch & ~{NUM_PB{pb.in_rd}}) | r_event;
        end
    end

    assign pb.pushbuttons = r_latch;
`else
    assign pb.pushbuttons = r_level;
`endif

endmodule
